register_file_banked: RTL

- Multi-bank CPU register file, generalised in data width, register count and bank count.
- Each bank has R0 hardwired to zero and R[NumRegs-1] as an auto-incrementing program counter.
- Adds run-time bank switching and a sequential spill/fill engine that streams the active bank to or from memory over valid/ready handshakes, for interrupt and context-switch save/restore.
- Sits between decode/writeback and the memory controller in the cpu16 core.

---
 rtl/register_file_banked.sv | 219 +++++++++++++++++++++
 1 files changed

// File: rtl/register_file_banked.sv
// -----------------------------------------------------------------------------
// register_file_banked
//
// Multi-bank CPU register file for the cpu16 core. Each bank holds NumRegs
// registers of DataWidth bits; R0 always reads as zero and R[NumRegs-1] is the
// program counter, which advances by PcStep on countEnable. The active bank can
// be switched at run time. A spill/fill engine streams R1..R[NumRegs-1] of the
// active bank out to memory (spill) or back in from memory (fill) over
// valid/ready handshakes. This is used for interrupt and context-switch
// save/restore.
//
// Optional feature (macro REGFILE_READ_BYPASS_EN):
//   When defined, a read port whose address matches an in-flight write
//   (writeEnable, idle, non-zero writeAddr) returns writeData combinationally.
//   programCounter is never bypassed. When undefined, reads return the stored
//   value only, so there is one cycle of write-to-read latency.
//
// Ports:
//   clk, rst          clock (rising edge), asynchronous active-high reset
//   countEnable       advance active-bank PC by PcStep
//   writeEnable/Addr/Data   register write into the active bank
//   readAddr1/2, readData1/2  combinational read ports (active bank)
//   programCounter    active-bank R[NumRegs-1]
//   bankSwitch/bankSel/activeBank  run-time bank selection
//   spillStart/fillStart  start a spill or fill of the active bank
//   busy, done        transfer in progress / one-cycle completion pulse
//   memIndex          register index of the current transfer word
//   memData/memValid/memReady    spill stream (engine -> memory)
//   fillData/fillValid/fillReady fill stream (memory -> engine)
// -----------------------------------------------------------------------------
module register_file_banked #(
    parameter int DataWidth  = 16,
    parameter int NumRegs    = 8,
    parameter int NumBanks   = 2,
    parameter int PcStep     = 1,
    parameter int IndexWidth = $clog2(NumRegs),
    parameter int BankWidth  = (NumBanks > 1) ? $clog2(NumBanks) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  countEnable,
    input  logic                  writeEnable,
    input  logic [IndexWidth-1:0] writeAddr,
    input  logic [DataWidth-1:0]  writeData,
    input  logic [IndexWidth-1:0] readAddr1,
    input  logic [IndexWidth-1:0] readAddr2,
    output logic [DataWidth-1:0]  readData1,
    output logic [DataWidth-1:0]  readData2,
    output logic [DataWidth-1:0]  programCounter,
    input  logic                  bankSwitch,
    input  logic [BankWidth-1:0]  bankSel,
    output logic [BankWidth-1:0]  activeBank,
    input  logic                  spillStart,
    input  logic                  fillStart,
    output logic                  busy,
    output logic                  done,
    output logic [IndexWidth-1:0] memIndex,
    output logic [DataWidth-1:0]  memData,
    output logic                  memValid,
    input  logic                  memReady,
    input  logic [DataWidth-1:0]  fillData,
    input  logic                  fillValid,
    output logic                  fillReady
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SPILL = 2'd1,
        ST_FILL  = 2'd2
    } state_t;

    localparam logic [IndexWidth-1:0] LastIndex = IndexWidth'(NumRegs - 1);
    localparam logic [DataWidth-1:0]  PcInc     = DataWidth'(PcStep);

    state_t                  state_q, state_d;
    logic [DataWidth-1:0]    regs_q [NumBanks][NumRegs];
    logic [DataWidth-1:0]    regs_d [NumBanks][NumRegs];
    logic [BankWidth-1:0]    bank_q, bank_d;
    logic [IndexWidth-1:0]   mem_index_q, mem_index_d;
    logic                    done_q, done_d;

    logic                    is_idle;
    logic                    last_index;
    logic                    spill_xfer;
    logic                    fill_xfer;

    assign is_idle    = (state_q == ST_IDLE);
    assign last_index = (mem_index_q == LastIndex);
    // A handshake completes whenever the engine's side is asserted (implied by
    // the state) and the memory side responds in the same cycle.
    assign spill_xfer = (state_q == ST_SPILL) && memReady;
    assign fill_xfer  = (state_q == ST_FILL) && fillValid;

    // ---------------------------------------------------------------------
    // State and storage registers
    // ---------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            bank_q      <= '0;
            mem_index_q <= '0;
            done_q      <= 1'b0;
            for (int b = 0; b < NumBanks; b++) begin
                for (int r = 0; r < NumRegs; r++) begin
                    regs_q[b][r] <= '0;
                end
            end
        end else begin
            state_q     <= state_d;
            bank_q      <= bank_d;
            mem_index_q <= mem_index_d;
            done_q      <= done_d;
            for (int b = 0; b < NumBanks; b++) begin
                for (int r = 0; r < NumRegs; r++) begin
                    regs_q[b][r] <= regs_d[b][r];
                end
            end
        end
    end

    // ---------------------------------------------------------------------
    // Next-state logic
    // ---------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: begin
                // Spill takes priority when both starts arrive together.
                if (spillStart) begin
                    state_d = ST_SPILL;
                end else if (fillStart) begin
                    state_d = ST_FILL;
                end
            end
            ST_SPILL: begin
                if (spill_xfer && last_index) begin
                    state_d = ST_IDLE;
                end
            end
            ST_FILL: begin
                if (fill_xfer && last_index) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // ---------------------------------------------------------------------
    // Control datapath: transfer index, bank select, completion pulse
    // ---------------------------------------------------------------------
    always_comb begin
        mem_index_d = mem_index_q;
        bank_d      = bank_q;
        done_d      = 1'b0;

        if (is_idle) begin
            // R0 is never transferred, so every transfer begins at index 1.
            if (spillStart || fillStart) begin
                mem_index_d = IndexWidth'(1);
            end
            if (bankSwitch && (int'(bankSel) < NumBanks)) begin
                bank_d = bankSel;
            end
        end else if (spill_xfer || fill_xfer) begin
            if (last_index) begin
                done_d = 1'b1;
            end else begin
                mem_index_d = mem_index_q + IndexWidth'(1);
            end
        end
    end

    // ---------------------------------------------------------------------
    // Register storage update
    // ---------------------------------------------------------------------
    always_comb begin
        regs_d = regs_q;
        if (is_idle) begin
            if (countEnable) begin
                regs_d[bank_q][LastIndex] = regs_q[bank_q][LastIndex] + PcInc;
            end
            // Applied after the increment so an explicit PC write wins.
            // bank_q (not bank_d) means a write alongside bankSwitch lands in
            // the old bank.
            if (writeEnable && (writeAddr != '0)) begin
                regs_d[bank_q][writeAddr] = writeData;
            end
        end else if (fill_xfer && (mem_index_q != '0)) begin
            regs_d[bank_q][mem_index_q] = fillData;
        end
    end

    // ---------------------------------------------------------------------
    // Outputs
    // ---------------------------------------------------------------------
    always_comb begin
        busy           = !is_idle;
        done           = done_q;
        memValid       = (state_q == ST_SPILL);
        fillReady      = (state_q == ST_FILL);
        memIndex       = mem_index_q;
        memData        = regs_q[bank_q][mem_index_q];
        activeBank     = bank_q;
        programCounter = regs_q[bank_q][LastIndex];

        readData1 = (readAddr1 == '0) ? '0 : regs_q[bank_q][readAddr1];
        readData2 = (readAddr2 == '0) ? '0 : regs_q[bank_q][readAddr2];
`ifdef REGFILE_READ_BYPASS_EN
        if (writeEnable && is_idle && (writeAddr != '0) && (readAddr1 == writeAddr)) begin
            readData1 = writeData;
        end
        if (writeEnable && is_idle && (writeAddr != '0) && (readAddr2 == writeAddr)) begin
            readData2 = writeData;
        end
`endif
    end

endmodule
